uart_tx_arb: RTL

//  Shares the single physical UART TX pin between the debug bridge and the application UART.

---
 rtl/uart_tx_arb_pkg.sv | 22 ++
 rtl/uart_tx_shifter.sv | 60 ++++++
 rtl/uart_tx_arb.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared state encodings, owner codes and frame constants for the arbitrated 8N1 transmitter.
package uart_tx_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_DBG  = 2'b01;
  localparam logic [1:0] OWN_APP  = 2'b10;

  localparam int FRAME_BITS = 10;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// Baud timing, frame bit counting and the 8N1 shift register behind the TX pad.
module uart_tx_shifter
  import uart_tx_arb_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk50_i,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_bit_done,
  output logic       o_last_bit,
  output logic       o_txd
);

  localparam int BW = $clog2(DIV);
  localparam int FW = $clog2(FRAME_BITS);

  logic [BW-1:0]           r_baud;
  logic [FW-1:0]           r_frameCnt;
  logic [FRAME_BITS-2:0]   r_shift;
  logic                    r_busy;
  logic                    r_txd;

  assign o_bit_done = r_busy && (r_baud == BW'(DIV - 1));
  assign o_last_bit = (r_frameCnt == FW'(FRAME_BITS - 2));
  assign o_busy     = r_busy;
  assign o_txd      = r_txd;

  // Start bit is driven straight from the load; ones shifted in behind the data form the stop bit.
  always_ff @(posedge clk50_i or posedge rst) begin
    if (rst) begin
      r_baud     <= '0;
      r_frameCnt <= '0;
      r_shift    <= '1;
      r_busy     <= 1'b0;
      r_txd      <= 1'b1;
    end else if (i_load) begin
      r_baud     <= '0;
      r_frameCnt <= '0;
      r_shift    <= {1'b1, i_data};
      r_busy     <= 1'b1;
      r_txd      <= 1'b0;
    end else if (o_bit_done) begin
      r_baud <= '0;
      if (r_frameCnt == FW'(FRAME_BITS - 1)) begin
        r_busy <= 1'b0;
        r_txd  <= 1'b1;
      end else begin
        r_frameCnt <= r_frameCnt + 1'b1;
        r_txd      <= r_shift[0];
        r_shift    <= {1'b1, r_shift[FRAME_BITS-2:1]};
      end
    end else if (r_busy) begin
      r_baud <= r_baud + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Two-requester arbiter sharing one UART TX pin between the debug bridge and the application,
// with round-robin on ties and an optional burst-hold window for the last owner.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 1000000,
  parameter int LOCK_GAP  = 2,
  parameter int DBG_FIRST = 1
) (
  input  logic       clk50_i,
  input  logic       rst,
  input  logic [7:0] dbg_data_i,
  input  logic       dbg_valid_i,
  output logic       dbg_accept_o,
  input  logic [7:0] app_data_i,
  input  logic       app_valid_i,
  output logic       app_accept_o,
  output logic       txd_o,
  output logic       busy_o,
  output logic [1:0] owner_o
);

  localparam int DIV      = calc_div(CLK_FREQ, BAUD);
  localparam int HOLD_CYC = (LOCK_GAP > 0) ? LOCK_GAP * DIV : 1;
  localparam int HW       = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_arb: CLK_FREQ/BAUD must be at least 2");
  end

  state_t         r_state;
  state_t         w_next;
  logic [1:0]     r_owner;
  logic [1:0]     r_last;
  logic [HW-1:0]  r_holdCnt;

  logic           w_grantDbg;
  logic           w_grantApp;
  logic           w_load;
  logic [7:0]     w_loadData;
  logic           w_shBusy;
  logic           w_bitDone;
  logic           w_lastBit;
  logic           w_txd;
  logic           w_holdDone;

  // Grants already include valid; reset masks them so no accept escapes while rst is high.
  always_comb begin
    w_grantDbg = 1'b0;
    w_grantApp = 1'b0;
    if (!rst && !w_shBusy) begin
      if (r_state == ST_IDLE) begin
        if (dbg_valid_i && !app_valid_i) begin
          w_grantDbg = 1'b1;
        end else if (app_valid_i && !dbg_valid_i) begin
          w_grantApp = 1'b1;
        end else if (dbg_valid_i && app_valid_i) begin
          if (r_last == OWN_DBG) begin
            w_grantApp = 1'b1;
          end else if (r_last == OWN_APP) begin
            w_grantDbg = 1'b1;
          end else if (DBG_FIRST != 0) begin
            w_grantDbg = 1'b1;
          end else begin
            w_grantApp = 1'b1;
          end
        end
      end else if (r_state == ST_HOLD) begin
        w_grantDbg = (r_owner == OWN_DBG) && dbg_valid_i;
        w_grantApp = (r_owner == OWN_APP) && app_valid_i;
      end
    end
  end

  assign w_load       = w_grantDbg | w_grantApp;
  assign w_loadData   = w_grantDbg ? dbg_data_i : app_data_i;
  assign dbg_accept_o = w_grantDbg;
  assign app_accept_o = w_grantApp;
  assign w_holdDone   = (r_holdCnt == HW'(HOLD_CYC - 1));

  uart_tx_shifter #(
    .DIV(DIV)
  ) u_shifter (
    .clk50_i   (clk50_i),
    .rst       (rst),
    .i_load    (w_load),
    .i_data    (w_loadData),
    .o_busy    (w_shBusy),
    .o_bit_done(w_bitDone),
    .o_last_bit(w_lastBit),
    .o_txd     (w_txd)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_load) w_next = ST_START;
      ST_START: if (w_bitDone) w_next = ST_DATA;
      ST_DATA:  if (w_bitDone && w_lastBit) w_next = ST_STOP;
      ST_STOP:  if (w_bitDone) w_next = (LOCK_GAP > 0) ? ST_HOLD : ST_IDLE;
      ST_HOLD: begin
        if (w_load) begin
          w_next = ST_START;
        end else if (w_holdDone) begin
          w_next = ST_IDLE;
        end
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50_i or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Owner is the visible lock and drops on every return to IDLE; last owner survives IDLE for round-robin.
  always_ff @(posedge clk50_i or posedge rst) begin
    if (rst) begin
      r_owner <= OWN_NONE;
      r_last  <= OWN_NONE;
    end else if (w_load) begin
      r_owner <= w_grantDbg ? OWN_DBG : OWN_APP;
      r_last  <= w_grantDbg ? OWN_DBG : OWN_APP;
    end else if (w_next == ST_IDLE && r_state != ST_IDLE) begin
      r_owner <= OWN_NONE;
    end
  end

  always_ff @(posedge clk50_i or posedge rst) begin
    if (rst) begin
      r_holdCnt <= '0;
    end else if (r_state == ST_HOLD && w_next == ST_HOLD) begin
      r_holdCnt <= r_holdCnt + 1'b1;
    end else begin
      r_holdCnt <= '0;
    end
  end

  assign txd_o   = w_txd;
  assign busy_o  = (r_state != ST_IDLE);
  assign owner_o = r_owner;

endmodule
